// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------------------
// fnd_pkg
// Shared constants for the Basys3 7-segment scan path:
//   - bit positions/widths of the packed 24-bit time word
//     ([23:19] hour, [18:13] min, [12:7] sec, [6:0] msec)
//   - active-low segment codes for 0..9 (bit order g..a) plus a blank code
//   - decimal-point blink threshold in centiseconds
//   - helper that merges segments and decimal point into one display byte
// ---------------------------------------------------------------------------
package fnd_pkg;

    localparam int HOUR_LSB = 19;
    localparam int HOUR_W   = 5;
    localparam int MIN_LSB  = 13;
    localparam int MIN_W    = 6;
    localparam int SEC_LSB  = 7;
    localparam int SEC_W    = 6;
    localparam int MSEC_LSB = 0;
    localparam int MSEC_W   = 7;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Below this many centiseconds the dp is lit, so it blinks once a second
    localparam int DP_BLINK_THRESH = 50;

    // Both segments and dp are active-low on the board
    function automatic logic [7:0] fnd_pack_byte(input logic [6:0] seg,
                                                 input logic       dp_lit);
        return {~dp_lit, seg};
    endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// ---------------------------------------------------------------------------
// fnd_seg_decoder
// Purely combinational BCD digit to 7-segment decoder (active-low, g..a).
// Ports:
//   digit : 4-bit digit value; anything above 9 comes out blank
//   seg   : 7-bit active-low segment pattern
// ---------------------------------------------------------------------------
module fnd_seg_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Out-of-range digits (from corrupt time fields) show nothing rather
    // than a misleading glyph
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// ---------------------------------------------------------------------------
// fnd_scan_controller
// Drives the Basys3 4-digit common-anode display from the packed time word.
// Digits are scanned right to left, each held for CLK_HZ/SCAN_HZ cycles
// (must be at least 2). A whole frame is drawn from one snapshot of the
// input taken as the scan wraps back to the rightmost digit, so a frame
// never mixes values from before and after a counter rollover.
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset, blanks the display
//   fnd_time : packed time {hour[4:0], min[5:0], sec[5:0], msec[6:0]}
//   sw_mode  : 0 shows sec.msec, 1 shows hour.min
//   fnd_com  : active-low digit enables, bit0 = rightmost digit
//   fnd_data : active-low segments, [7] = dp, [6:0] = g..a
// ---------------------------------------------------------------------------
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] fnd_time,
    input  logic        sw_mode,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_data
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]       digit_sel_q, digit_sel_d;
    logic [23:0]      snap_time_q, snap_time_d;
    logic             snap_mode_q, snap_mode_d;
    logic [3:0]       fnd_com_q, fnd_com_d;
    logic [7:0]       fnd_data_q, fnd_data_d;

    logic             tick;
    logic             snap_load;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
    logic [3:0]       digit_val;
    logic             dp_lit;
    logic [6:0]       seg;

    // Dwell timer, digit pointer and frame snapshot. The snapshot is loaded
    // on the same edge that wraps the pointer to digit 0, so the new frame
    // starts with fresh data and stays frozen until the next wrap.
    always_comb begin
        tick        = (tick_cnt_q == CNT_W'(DIV - 1));
        tick_cnt_d  = tick ? '0 : tick_cnt_q + CNT_W'(1);
        digit_sel_d = tick ? digit_sel_q + 2'd1 : digit_sel_q;
        snap_load   = tick && (digit_sel_q == 2'd3);
        snap_time_d = snap_load ? fnd_time : snap_time_q;
        snap_mode_d = snap_load ? sw_mode  : snap_mode_q;
    end

    // Split the snapshot into decimal digits for the digit being scanned
    always_comb begin
        hour      = snap_time_q[HOUR_LSB +: HOUR_W];
        min       = snap_time_q[MIN_LSB  +: MIN_W];
        sec       = snap_time_q[SEC_LSB  +: SEC_W];
        msec      = snap_time_q[MSEC_LSB +: MSEC_W];
        digit_val = 4'd0;
        if (snap_mode_q) begin
            case (digit_sel_q)
                2'd0:    digit_val = 4'(min  % 6'd10);
                2'd1:    digit_val = 4'(min  / 6'd10);
                2'd2:    digit_val = 4'(hour % 5'd10);
                default: digit_val = 4'(hour / 5'd10);
            endcase
        end else begin
            case (digit_sel_q)
                2'd0:    digit_val = 4'(msec % 7'd10);
                2'd1:    digit_val = 4'(msec / 7'd10);
                2'd2:    digit_val = 4'(sec  % 6'd10);
                default: digit_val = 4'(sec  / 6'd10);
            endcase
        end
        // The dp separates the two displayed fields; in sec.msec mode it
        // blinks with the half-second
        dp_lit = (digit_sel_q == 2'd2) &&
                 (snap_mode_q || (msec < MSEC_W'(DP_BLINK_THRESH)));
    end

    fnd_seg_decoder u_seg_decoder (
        .digit (digit_val),
        .seg   (seg)
    );

    // Registered drive to the pins keeps digit enable and segments aligned
    always_comb begin
        fnd_com_d  = ~(4'b0001 << digit_sel_q);
        fnd_data_d = fnd_pack_byte(seg, dp_lit);
    end

    // State and output registers; reset blanks the display and restarts
    // the scan at digit 0 with an all-zero snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q  <= '0;
            digit_sel_q <= 2'd0;
            snap_time_q <= 24'd0;
            snap_mode_q <= 1'b0;
            fnd_com_q   <= 4'b1111;
            fnd_data_q  <= 8'hFF;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            digit_sel_q <= digit_sel_d;
            snap_time_q <= snap_time_d;
            snap_mode_q <= snap_mode_d;
            fnd_com_q   <= fnd_com_d;
            fnd_data_q  <= fnd_data_d;
        end
    end

    assign fnd_com  = fnd_com_q;
    assign fnd_data = fnd_data_q;

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Consumes the 24-bit packed time selected by the upstream watch/stopwatch selector and drives the Basys3 4-digit common-anode 7-segment display. It time-multiplexes the digits at a fixed scan rate and splits the packed fields into decimal digits. A mode switch picks the displayed pair, sec.msec or hour.min. Each frame is drawn from one registered snapshot of the input, so digits never tear while the counters roll over.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
SCAN_HZ, 1_000, per-digit dwell rate; DIV = CLK_HZ/SCAN_HZ cycles per digit; DIV >= 2 is required.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
fnd_time  input  24  packed time: [23:19] hour, [18:13] min, [12:7] sec, [6:0] msec (centiseconds 0-99)
sw_mode  input  1  0 = sec.msec, 1 = hour.min
fnd_com  output  4  digit enables, active-low; bit0 = rightmost digit
fnd_data  output  8  segments, active-low; [7] = dp, [6:0] = g..a

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. While rst is high at a clock edge:
  - tick_cnt = 0, digit_sel = 0, snapshot time = 0, snapshot mode = 0.
  - fnd_com = 4'b1111 and fnd_data = 8'hFF. All digits are blank.
- Reset mid-frame acts the same way: the block blanks on the next edge and the scan restarts at digit 0.
- Tick generator: tick_cnt counts 0 to DIV-1 and wraps. tick = (tick_cnt == DIV-1).
- Digit counter: on tick, digit_sel increments modulo 4 (3 wraps to 0).
- Snapshot: on a tick with digit_sel == 3, fnd_time and sw_mode are registered into the snapshot.
  - The new snapshot is in use from the cycle digit_sel becomes 0.
  - Input changes during a frame do not affect that frame.
  - The first frame after reset therefore displays all zeros.
- Digit extraction uses unsigned /10 and %10 on the snapshot fields:
  - mode 0: d0 = msec%10, d1 = msec/10, d2 = sec%10, d3 = sec/10.
  - mode 1: d0 = min%10, d1 = min/10, d2 = hour%10, d3 = hour/10.
  - A digit value > 9 (out-of-range field, e.g. msec = 127 gives d1 = 12) displays blank, segments 7'h7F.
- Segment code, [6:0] active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). With dp off, fnd_data = 8'h80 | code.
- Decimal point (bit 7 = 0 means lit) is shown only on digit 2:
  - mode 0: lit when snapshot msec < 50, giving a 1 Hz blink.
  - mode 1: always lit.
- Output register: fnd_com and fnd_data are registered and reflect digit_sel and snapshot with exactly 1 cycle latency.
  - fnd_com = ~(4'b0001 << digit_sel).
  - Exactly one digit is enabled outside reset.
  - The first cycle after reset release gives fnd_com = 4'b1110 and fnd_data = 8'hC0.
- Each digit is held for DIV cycles. A full frame is 4*DIV cycles.
- Simultaneous events: a tick on digit 3 both wraps digit_sel and loads the snapshot in the same edge. This case has no priority conflict.

Decomposition:
- Shared package fnd_pkg holds:
  - field LSB/width constants (HOUR_LSB=19/5, MIN_LSB=13/6, SEC_LSB=7/6, MSEC_LSB=0/7)
  - the 10 segment constants and SEG_BLANK = 7'h7F
  - DP_BLINK_THRESH = 50
- One natural combinational sub-module, fnd_seg_decoder: 4-bit digit to 7-bit active-low segments, with blank for values > 9.
- Tick generator, digit counter, snapshot and digit split stay in the top module.

Test Plan:
All scenarios use CLK_HZ=40, SCAN_HZ=10 (DIV=4).
1. Reset: hold rst 3 cycles -> fnd_com=1111, fnd_data=FF. Release -> next edge gives 1110/C0. fnd_com then steps 1101, 1011, 0111, each for 4 cycles.
2. fnd_time={5'd12,6'd34,6'd56,7'd78}, sw_mode=0, run past first frame -> second frame shows:
   - d0: 1110/80
   - d1: 1101/F8
   - d2: 1011/82 (dp off, 78 >= 50)
   - d3: 0111/92
3. Same time with sw_mode=1 -> next frame shows d0 99, d1 B0, d2 24 (dp lit), d3 F9.
4. msec=23, sec=56, mode 0 -> d2 = 02 (6 with dp lit). Change msec to 60 -> d2 = 82 from the following frame.
5. Change fnd_time while digit_sel=1 -> digits 2 and 3 of that frame still show the old values. The new value appears only after the wrap to digit 0.
6. msec=127 -> d1 = FF (blank) and d0 = F8. Assert rst while digit_sel=2 -> next edge gives 1111/FF, and scanning restarts at digit 0 with an all-zero snapshot.
